mux_nto1_rr: RTL and testbench
==============================

MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 SHALL have local parameter CW = max(1, clog2(N)): channel-index width.
REQ-004 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-008 in_ready  output  N  per-channel accept; at most one bit is high per cycle.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  W  selected word, registered.
REQ-011 out_ch  output  CW  index of the channel that supplied out_data, registered.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 SHALL keep a 2-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL define can_load = EMPTY, or (FULL and out_ready).
REQ-015 SHALL compute grant combinationally: first i with in_valid[i]=1, searching cyclically from (last+1) mod N.
REQ-016 SHALL drive in_ready[g]=1 only when a grant g exists and can_load=1; all other in_ready bits are 0.
REQ-017 SHALL never let in_ready depend on in_valid of non-granted channels beyond the grant search; there is no combinational path from out_ready to out_data.
REQ-018 On transfer (in_valid[g] and in_ready[g]), SHALL load out_data=in_data[g] and out_ch=g, update last=g, and go to or stay in FULL.
REQ-019 SHALL give 1-cycle latency: a word accepted at edge k appears on out_data/out_valid after edge k.
REQ-020 In FULL with out_ready=1 and no transfer, SHALL go to EMPTY; out_data and out_ch hold their last values.
REQ-021 In FULL with out_ready=0, SHALL hold out_data, out_ch and out_valid, and keep all in_ready bits at 0.
REQ-022 Simultaneous drain and load (FULL, out_ready=1, grant present) SHALL stay FULL with the new word: full throughput, one word per cycle.
REQ-023 SHALL leave last unchanged in any cycle without a transfer.
REQ-024 Pointer wrap: after last=N-1, the search SHALL start at channel 0.
REQ-025 With no in_valid bits set, SHALL produce no grant and leave all in_ready bits at 0.

Reset
REQ-026 While rst=1, regardless of clk, SHALL force out_valid=0, out_data=0, out_ch=0, last=N-1 (channel 0 has first priority), and EMPTY.
REQ-027 Reset mid-transfer SHALL discard the held word; the first post-reset grant follows REQ-026 priority.
REQ-028 SHALL drive all in_ready bits to 0 while rst=1.

Configuration
REQ-029 Macro MUX_NTO1_FIXED_PRIO_EN: when defined, SHALL use fixed priority (lowest requesting index wins; last is unused and need not exist).
REQ-030 Without MUX_NTO1_FIXED_PRIO_EN, SHALL use round-robin per REQ-015/REQ-018/REQ-024; the interface is identical in both builds.

Verification (N=4, W=8, round-robin unless stated)
REQ-031 Reset, then in_valid=4'b1111, data ch0..3=0x10,0x11,0x12,0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data matches, out_valid stays 1.
REQ-032 Only ch2 valid with 0xA5, out_ready=0 for 3 cycles -> one transfer only, out_data=0xA5 and out_ch=2 held, in_ready=0 while FULL; out_ready=1 -> next word loads in the same cycle.
REQ-033 last=3, in_valid=4'b1001 -> grant ch0, then ch3, then ch0 (wrap).
REQ-034 Assert rst asynchronously while FULL with out_data=0x5A -> out_valid=0, out_data=0 immediately without a clock edge; after release, in_valid=4'b0110 -> ch1 granted first.
REQ-035 MUX_NTO1_FIXED_PRIO_EN defined, in_valid=4'b1010 held, out_ready=1 -> out_ch=1 every cycle and ch3 is never granted.
REQ-036 Every cycle, the bench SHALL check that in_ready is one-hot or zero and that no word is lost or duplicated, using a scoreboard.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N-to-1 registered multiplexer with a one-word output register.
// Grants channels round-robin, starting the search after the last granted channel.
// Define MUX_NTO1_FIXED_PRIO_EN for fixed priority instead: the lowest requesting
// index wins and no round-robin pointer is kept. The interface is the same in both builds.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - per-channel request, bit i = channel i
//   in_data   - channel data, channel i at [i*W +: W]
//   in_ready  - per-channel accept (combinational), at most one bit high
//   out_valid - output register holds a word
//   out_data  - selected word (registered)
//   out_ch    - index of the channel that supplied out_data (registered)
//   out_ready - downstream accept
module mux_nto1_rr #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_ch,
    input  logic            out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [CW-1:0]   ch_q, ch_d;
`ifndef MUX_NTO1_FIXED_PRIO_EN
    logic [CW-1:0]   last_q, last_d;
    int unsigned     cand;
`endif

    logic            gnt_found;
    int unsigned     gnt_idx;
    logic            can_load;
    logic            xfer;

    // Grant search over requesting channels
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 0;
`ifdef MUX_NTO1_FIXED_PRIO_EN
        for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_found && in_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = i;
            end
        end
`else
        cand = 0;
        // Offsets 1..N from last, so last itself is searched at the very end
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`endif
    end

    // Load permission and transfer; reset blocks any accept
    always_comb begin
        can_load = (state_q == EMPTY) || out_ready;
        xfer     = gnt_found && can_load && !rst;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = '0;
        out_valid = (state_q == FULL);
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Datapath next values: capture on transfer, hold otherwise
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
`ifndef MUX_NTO1_FIXED_PRIO_EN
        last_d = last_q;
`endif
        if (xfer) begin
            data_d = in_data[gnt_idx*W +: W];
            ch_d   = CW'(gnt_idx);
`ifndef MUX_NTO1_FIXED_PRIO_EN
            last_d = CW'(gnt_idx);
`endif
        end
    end

    // Datapath registers; last resets to N-1 so channel 0 is searched first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ch_q   <= '0;
`ifndef MUX_NTO1_FIXED_PRIO_EN
            last_q <= CW'(N - 1);
`endif
        end else begin
            data_q <= data_d;
            ch_q   <= ch_d;
`ifndef MUX_NTO1_FIXED_PRIO_EN
            last_q <= last_d;
`endif
        end
    end

    assign out_data = data_q;
    assign out_ch   = ch_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed test of mux_nto1_rr (N=4, W=8) with a per-cycle
// scoreboard that follows every accepted word from input to output.
module tb_mux_nto1_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW+W-1:0] sb[$];

    mux_nto1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int ch, input logic [7:0] v);
        in_data[ch*W +: W] = v;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [CW-1:0] c, input logic [W-1:0] d);
        chk({tag, "_valid"}, 64'(out_valid), 64'(v));
        chk({tag, "_ch"},    64'(out_ch),    64'(c));
        chk({tag, "_data"},  64'(out_data),  64'(d));
    endtask

    // Mid-cycle monitor: sees the values that the next rising edge will act on
    always @(negedge clk) begin
        logic [CW+W-1:0] exp_w;
        chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'(1));
        if (rst) begin
            chk("in_ready_in_reset", 64'(in_ready), 64'(0));
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    exp_w = sb.pop_front();
                    chk("sb_word", 64'({out_ch, out_data}), 64'(exp_w));
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    sb.push_back({CW'(i), in_data[i*W +: W]});
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values before any clock edge
        #1;
        chk_out("rst", 1'b0, 2'd0, 8'h00);
        in_valid = 4'b1111;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        tick();
        tick();
        rst      = 1'b0;
        in_valid = '0;

`ifdef MUX_NTO1_FIXED_PRIO_EN
        // Fixed priority: ch1 always beats ch3
        set_d(1, 8'h21);
        set_d(3, 8'h23);
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        chk("fp_in_ready0", 64'(in_ready), 64'(4'b0010));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("fp", 1'b1, 2'd1, 8'h21);
            chk("fp_in_ready", 64'(in_ready), 64'(4'b0010));
        end
        in_valid = '0;
        tick();
        chk("fp_drain", 64'(out_valid), 64'(0));
`else
        // All channels requesting: 0,1,2,3,0 at full throughput
        set_d(0, 8'h10);
        set_d(1, 8'h11);
        set_d(2, 8'h12);
        set_d(3, 8'h13);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 64'(in_ready), 64'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("rr_seq", 1'b1, CW'(k % 4), 8'h10 + 8'(k % 4));
        end
        in_valid = '0;
        tick();
        chk_out("drain_hold", 1'b0, 2'd0, 8'h10);

        // Back-pressure: one word held, no further accepts
        set_d(2, 8'hA5);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 64'(in_ready), 64'(4'b0100));
        tick();
        for (int r = 0; r < 3; r++) begin
            chk_out("bp_hold", 1'b1, 2'd2, 8'hA5);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        chk_out("bp_hold_end", 1'b1, 2'd2, 8'hA5);
        set_d(2, 8'hA6);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(4'b0100));
        tick();
        chk_out("bp_reload", 1'b1, 2'd2, 8'hA6);
        in_valid = '0;
        tick();
        chk("bp_drain", 64'(out_valid), 64'(0));

        // Wrap: last=3, ch0 and ch3 alternate
        set_d(3, 8'h33);
        in_valid = 4'b1000;
        tick();
        chk_out("wrap_pre", 1'b1, 2'd3, 8'h33);
        set_d(0, 8'h40);
        in_valid = 4'b1001;
        #1;
        chk("wrap_ready", 64'(in_ready), 64'(4'b0001));
        tick();
        chk_out("wrap_a", 1'b1, 2'd0, 8'h40);
        tick();
        chk_out("wrap_b", 1'b1, 2'd3, 8'h33);
        tick();
        chk_out("wrap_c", 1'b1, 2'd0, 8'h40);
        in_valid = '0;
        tick();
        chk("wrap_drain", 64'(out_valid), 64'(0));

        // Asynchronous reset while FULL discards the word
        set_d(0, 8'h5A);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        chk_out("ar_full", 1'b1, 2'd0, 8'h5A);
        in_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        chk_out("ar_async", 1'b0, 2'd0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        set_d(1, 8'h61);
        set_d(2, 8'h62);
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        #1;
        chk("ar_first_ready", 64'(in_ready), 64'(4'b0010));
        tick();
        chk_out("ar_first", 1'b1, 2'd1, 8'h61);
        tick();
        chk_out("ar_second", 1'b1, 2'd2, 8'h62);
        in_valid = '0;
        tick();
        chk("ar_drain", 64'(out_valid), 64'(0));
`endif

        // No in_valid: no grant
        #1;
        chk("idle_ready", 64'(in_ready), 64'(0));
        tick();
        chk("sb_residue", 64'(sb.size()), 64'(out_valid ? 1 : 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
